// File: rtl/visualizador_7seg_mux_pkg.sv
// rtl/visualizador_7seg_mux_pkg.sv - shared widths and constants for the 7-segment display scanner
package visualizador_7seg_mux_pkg;

  localparam int          BUS_DAT          = 16;
  localparam logic [6:0]  SEG_APAGADO      = 7'b1111111;
  localparam int          DIV_REFRESCO_DEF = 50000;

endpackage

// File: rtl/visualizador_7seg_mux_decodificador.sv
// rtl/visualizador_7seg_mux_decodificador.sv - hex nibble to active-low {g,f,e,d,c,b,a} segments
module decodificador_hex_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = 7'b1111111;
    case (nibble)
      4'h0: segmentos = 7'b1000000;
      4'h1: segmentos = 7'b1111001;
      4'h2: segmentos = 7'b0100100;
      4'h3: segmentos = 7'b0110000;
      4'h4: segmentos = 7'b0011001;
      4'h5: segmentos = 7'b0010010;
      4'h6: segmentos = 7'b0000010;
      4'h7: segmentos = 7'b1111000;
      4'h8: segmentos = 7'b0000000;
      4'h9: segmentos = 7'b0010000;
      4'hA: segmentos = 7'b0001000;
      4'hB: segmentos = 7'b0000011;
      4'hC: segmentos = 7'b1000110;
      4'hD: segmentos = 7'b0100001;
      4'hE: segmentos = 7'b0000110;
      4'hF: segmentos = 7'b0001110;
      default: segmentos = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/visualizador_7seg_mux.sv
// rtl/visualizador_7seg_mux.sv - multiplexed common-anode hex display with frame-aligned value snapshot
module visualizador_7seg_mux
  import visualizador_7seg_mux_pkg::*;
#(
  parameter int CANT_BITS    = BUS_DAT,
  parameter int NUM_DIG      = 4,
  parameter int DIV_REFRESCO = DIV_REFRESCO_DEF,
  parameter int BLANK_CEROS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CANT_BITS-1:0] dato,
  input  logic                 cargar,
  output logic [6:0]           segmentos,
  output logic                 punto,
  output logic [NUM_DIG-1:0]   anodos,
  output logic                 fin_barrido
);

  localparam int PW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int EW = 4 * NUM_DIG;

  logic [PW-1:0]        prescaler;
  logic [IW-1:0]        idx;
  logic [CANT_BITS-1:0] pendiente;
  logic [CANT_BITS-1:0] visible;
  logic [EW-1:0]        ext;
  logic [EW-1:0]        resto;
  logic [6:0]           seg_dec;
  logic                 tick;
  logic                 fin_marco;
  logic                 apagar;

  // Bits of the value beyond CANT_BITS read as zero on the display.
  for (genvar b = 0; b < EW; b++) begin : g_ext
    if (b < CANT_BITS) begin : g_bit
      assign ext[b] = visible[b];
    end else begin : g_cero
      assign ext[b] = 1'b0;
    end
  end

  assign tick      = (prescaler == PW'(DIV_REFRESCO - 1));
  assign fin_marco = tick && (idx == IW'(NUM_DIG - 1));
  assign resto     = ext >> {idx, 2'b00};
  // Digit 0 always shows; higher digits blank when they and everything above are zero.
  assign apagar    = (BLANK_CEROS != 0) && (idx != '0) && (resto == '0);

  decodificador_hex_7seg u_dec (
    .nibble    (resto[3:0]),
    .segmentos (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler   <= '0;
      idx         <= '0;
      pendiente   <= '0;
      visible     <= '0;
      anodos      <= '1;
      segmentos   <= SEG_APAGADO;
      punto       <= 1'b1;
      fin_barrido <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        idx <= (idx == IW'(NUM_DIG - 1)) ? '0 : idx + IW'(1);
      end
      if (cargar) begin
        pendiente <= dato;
      end
      // Snapshot only at the frame boundary so a frame never mixes two values.
      if (fin_marco) begin
        visible <= pendiente;
      end
      anodos      <= ~(NUM_DIG'(1) << idx);
      segmentos   <= apagar ? SEG_APAGADO : seg_dec;
      punto       <= (idx != '0);
      fin_barrido <= fin_marco;
    end
  end

endmodule

// File: tb/tb_visualizador_7seg_mux.sv
// tb/tb_visualizador_7seg_mux.sv - self-checking bench for visualizador_7seg_mux
module tb_visualizador_7seg_mux;

  localparam int DIV   = 4;
  localparam int ND    = 4;
  localparam int CB    = 16;
  localparam int FRAME = DIV * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cargar = 1'b0;
  logic [CB-1:0] dato = '0;

  logic [6:0]    seg_b, seg_n;
  logic          punto_b, punto_n;
  logic [ND-1:0] an_b, an_n;
  logic          fin_b, fin_n;

  visualizador_7seg_mux #(.CANT_BITS(CB), .NUM_DIG(ND), .DIV_REFRESCO(DIV), .BLANK_CEROS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .dato(dato), .cargar(cargar),
    .segmentos(seg_b), .punto(punto_b), .anodos(an_b), .fin_barrido(fin_b)
  );

  visualizador_7seg_mux #(.CANT_BITS(CB), .NUM_DIG(ND), .DIV_REFRESCO(DIV), .BLANK_CEROS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .dato(dato), .cargar(cargar),
    .segmentos(seg_n), .punto(punto_n), .anodos(an_n), .fin_barrido(fin_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int c = 0;
  logic [CB-1:0] pend_q[$];
  logic [6:0] hex_tab[16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [CB-1:0] dato;
    logic [6:0]    seg_blank[ND];
    logic [6:0]    seg_full[ND];
  } vec_t;
  vec_t tab[4];

  // Expected {anodos, segmentos, punto, fin_barrido} after the c-th edge since reset.
  function automatic logic [12:0] modelo(input int cc, input bit blank);
    int d, f, nib;
    logic [CB-1:0] vis;
    logic [6:0] seg;
    logic [3:0] an;
    if (cc == 0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    d   = ((cc - 1) / DIV) % ND;
    f   = (cc - 1) / FRAME;
    vis = (f == 0) ? '0 : pend_q[FRAME * f - 1];
    nib = (int'(vis) >> (4 * d)) & 15;
    if (blank && d > 0 && (int'(vis) >> (4 * d)) == 0) seg = 7'h7F;
    else seg = hex_tab[nib];
    an = 4'hF;
    an[d] = 1'b0;
    return {an, seg, 1'(d != 0), 1'(cc % FRAME == 0)};
  endfunction

  task automatic comparar();
    logic [12:0] eb, en;
    eb = modelo(c, 1'b1);
    en = modelo(c, 1'b0);
    tests++;
    if ({an_b, seg_b, punto_b, fin_b} !== eb) begin
      fails++;
      $display("FAIL blank_ceros=1 edge %0d: got an=%b seg=%b pt=%b fin=%b, want %b_%b_%b_%b",
               c, an_b, seg_b, punto_b, fin_b, eb[12:9], eb[8:2], eb[1], eb[0]);
    end
    tests++;
    if ({an_n, seg_n, punto_n, fin_n} !== en) begin
      fails++;
      $display("FAIL blank_ceros=0 edge %0d: got an=%b seg=%b pt=%b fin=%b, want %b_%b_%b_%b",
               c, an_n, seg_n, punto_n, fin_n, en[12:9], en[8:2], en[1], en[0]);
    end
  endtask

  // Advance the model with the inputs the coming edge will sample, then check after the edge.
  task automatic step();
    if (!rst_n) begin
      c = 0;
      pend_q.delete();
      pend_q.push_back('0);
    end else begin
      c++;
      pend_q.push_back(cargar ? dato : pend_q[c - 1]);
    end
    @(posedge clk);
    #1;
    comparar();
  endtask

  task automatic run_to(input int objetivo);
    for (int n = 0; n < 200 && c < objetivo; n++) step();
  endtask

  task automatic reiniciar();
    rst_n = 1'b0;
    cargar = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    tab[0] = '{16'hA3F0, '{7'b1000000, 7'b0001110, 7'b0110000, 7'b0001000},
                         '{7'b1000000, 7'b0001110, 7'b0110000, 7'b0001000}};
    tab[1] = '{16'h0005, '{7'b0010010, 7'h7F, 7'h7F, 7'h7F},
                         '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000}};
    tab[2] = '{16'h00F0, '{7'b1000000, 7'b0001110, 7'h7F, 7'h7F},
                         '{7'b1000000, 7'b0001110, 7'b1000000, 7'b1000000}};
    tab[3] = '{16'h0000, '{7'b1000000, 7'h7F, 7'h7F, 7'h7F},
                         '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};

    // Reset held for three cycles.
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) step();
    rst_n = 1'b1;

    // Table-driven loads: value pulsed on edge 1, checked mid-digit in frame 1.
    for (int i = 0; i < 4; i++) begin
      reiniciar();
      dato = tab[i].dato;
      cargar = 1'b1;
      step();
      cargar = 1'b0;
      dato = $urandom;
      for (int n = 0; n < 31; n++) begin
        step();
        if (c >= 17 && c <= 32 && ((c - 17) % DIV) == 1) begin
          int k;
          k = (c - 17) / DIV;
          tests++;
          if (seg_b !== tab[i].seg_blank[k] || seg_n !== tab[i].seg_full[k] || an_b[k] !== 1'b0) begin
            fails++;
            $display("FAIL table %h digit %0d: got seg=%b/%b an=%b, want seg=%b/%b an[%0d]=0",
                     tab[i].dato, k, seg_b, seg_n, an_b, tab[i].seg_blank[k], tab[i].seg_full[k], k);
          end
        end
      end
    end

    // Tear-free: new value loaded while digit 2 of frame 2 is lit.
    reiniciar();
    dato = 16'h5678; cargar = 1'b1; step(); cargar = 1'b0;
    run_to(2 * FRAME + 2 * DIV + 2);
    dato = 16'h1234; cargar = 1'b1; step(); cargar = 1'b0;
    run_to(4 * FRAME + 2);

    // Load on the very frame-boundary edge.
    run_to(5 * FRAME - 1);
    dato = 16'hBEEF; cargar = 1'b1; step(); cargar = 1'b0;
    run_to(7 * FRAME + 2);

    // Reset during digit 2.
    run_to(8 * FRAME + 2 * DIV + 1);
    reiniciar();
    run_to(FRAME + 4);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      cargar = ($urandom_range(0, 9) == 0);
      dato = $urandom;
      if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
